// File: rtl/hilo_md_ctrl_pkg.sv
// Shared encodings and helpers for the multiply/divide sequencer.
package hilo_md_ctrl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 5;

  // Multiply/divide operation encodings
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DZ   = 3'd4,
    DONE = 3'd5
  } md_state_e;

  // HI/LO result pair
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Two's complement negate
  function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
    return XLEN'(~x + XLEN'(1));
  endfunction

  // Magnitude of a signed word; 0x80000000 maps to 2^31 as unsigned
  function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/hilo_md_ctrl_if.sv
// Pipeline <-> multiply/divide sequencer handshake and HI/LO write port.
interface hilo_md_ctrl_if;
  import hilo_md_ctrl_pkg::*;

  logic            start;
  md_op_e          op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            flush;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] wHiData;
  logic            whi;
  logic [XLEN-1:0] wLoData;
  logic            wlo;

  modport master (
    output start, op, rs_data, rt_data, flush,
    input  busy, done, div_by_zero, wHiData, whi, wLoData, wlo
  );

  modport slave (
    input  start, op, rs_data, rt_data, flush,
    output busy, done, div_by_zero, wHiData, whi, wLoData, wlo
  );

endinterface

// File: rtl/hilo_md_ctrl_md_div_core.sv
// Iterative unsigned 32-bit restoring divider, one quotient bit per step.
module md_div_core
  import hilo_md_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic            fits;

  // Shift next dividend bit into the partial remainder and trial-subtract
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      if (fits) begin
        rem_d = XLEN'(shifted - {1'b0, dvs_q});
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_md_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the HI/LO write strobes.
module hilo_md_ctrl
  import hilo_md_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
)(
  input  logic           clk,
  input  logic           rst,
  hilo_md_ctrl_if.slave  md
);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e          op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;
  logic            whi_q, whi_d;
  logic            wlo_q, wlo_d;
  hilo_t           res_q, res_d;

  logic            div_load;
  logic            div_step;
  logic [XLEN-1:0] div_a;
  logic [XLEN-1:0] div_b;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic            sgn_in;
  logic            sgn_mul;
  logic [2*XLEN-1:0] ma;
  logic [2*XLEN-1:0] mb;
  logic [2*XLEN-1:0] prod;

  md_div_core u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (div_a),
    .divisor   (div_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Product of latched operands; the low 64 bits are exact for both signednesses
  always_comb begin
    sgn_mul = (op_q == MD_MULT);
    ma      = {{XLEN{sgn_mul & a_q[XLEN-1]}}, a_q};
    mb      = {{XLEN{sgn_mul & b_q[XLEN-1]}}, b_q};
    prod    = ma * mb;
  end

  // Divider operands: magnitudes for DIV, raw values for DIVU
  always_comb begin
    sgn_in = (md.op == MD_DIV);
    div_a  = sgn_in ? abs32(md.rs_data) : md.rs_data;
    div_b  = sgn_in ? abs32(md.rt_data) : md.rt_data;
  end

  // Next-state, operand capture and registered output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    whi_d    = 1'b0;
    wlo_d    = 1'b0;
    res_d    = '0;
    div_load = 1'b0;
    div_step = 1'b0;

    case (state_q)
      IDLE: begin
        if (md.start && !md.flush) begin
          op_d   = md.op;
          a_d    = md.rs_data;
          b_d    = md.rt_data;
          cnt_d  = '0;
          qneg_d = sgn_in & (md.rs_data[XLEN-1] ^ md.rt_data[XLEN-1]);
          rneg_d = sgn_in & md.rs_data[XLEN-1];
          if (md.op == MD_MULT || md.op == MD_MULTU) begin
            state_d = MUL;
          end else if (md.rt_data == '0) begin
            state_d = DZ;
          end else begin
            state_d  = DIV;
            div_load = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      DIV: begin
        div_step = 1'b1;
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      FIX:     state_d = DONE;
      DZ:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Squash: abandon whatever is in flight, nothing is written
    if (md.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    busy_d = (state_d == MUL) || (state_d == DIV) ||
             (state_d == FIX) || (state_d == DZ);

    // Result lands in the output registers on the edge that enters DONE
    if (state_d == DONE) begin
      done_d = 1'b1;
      case (state_q)
        MUL: begin
          res_d.hi = prod[2*XLEN-1:XLEN];
          res_d.lo = prod[XLEN-1:0];
          whi_d    = 1'b1;
          wlo_d    = 1'b1;
        end
        FIX: begin
          res_d.hi = rneg_q ? neg32(div_rem) : div_rem;
          res_d.lo = qneg_q ? neg32(div_quo) : div_quo;
          whi_d    = 1'b1;
          wlo_d    = 1'b1;
        end
        DZ: begin
          res_d.hi = a_q;
          res_d.lo = '1;
          dbz_d    = 1'b1;
        end
        default: res_d = '0;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      whi_q   <= 1'b0;
      wlo_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      whi_q   <= whi_d;
      wlo_q   <= wlo_d;
      res_q   <= res_d;
    end
  end

  // A flush arriving in the DONE cycle must still kill the completion and writes
  assign md.busy        = busy_q;
  assign md.done        = done_q & ~md.flush;
  assign md.div_by_zero = dbz_q & ~md.flush;
  assign md.whi         = whi_q & ~md.flush;
  assign md.wlo         = wlo_q & ~md.flush;
  assign md.wHiData     = md.flush ? '0 : res_q.hi;
  assign md.wLoData     = md.flush ? '0 : res_q.lo;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed-vector bench for the multiply/divide sequencer.
module tb_hilo_md_ctrl;
  import hilo_md_ctrl_pkg::*;

  localparam int MULC = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  hilo_md_ctrl_if md_if ();

  hilo_md_ctrl #(.MUL_CYCLES(MULC)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge; returns in cycle k+1
  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    md_if.op      = op;
    md_if.rs_data = a;
    md_if.rt_data = b;
    md_if.start   = 1'b1;
    tick();
    md_if.start   = 1'b0;
  endtask

  // Cycles since accept until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 1;
    while (md_if.done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  // Count done/write events over n cycles
  task automatic watch(input int n, output int ev);
    ev = 0;
    repeat (n) begin
      if (md_if.done || md_if.whi || md_if.wlo) ev++;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    int   lat;
    logic we;
    we = ~exp_dbz;
    issue(op, a, b);
    chk({tag, " busy"}, 64'(md_if.busy), 64'(1));
    wait_done(lat);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " hi"}, 64'(md_if.wHiData), 64'(exp_hi));
    chk({tag, " lo"}, 64'(md_if.wLoData), 64'(exp_lo));
    chk({tag, " flags"}, 64'({md_if.whi, md_if.wlo, md_if.div_by_zero, md_if.busy}),
        64'({we, we, exp_dbz, 1'b0}));
    tick();
    chk({tag, " idle"}, 64'({md_if.done, md_if.busy, md_if.whi, md_if.wlo, md_if.wHiData, md_if.wLoData}),
        64'(0));
  endtask

  initial begin
    int          ev;
    int          lat;
    int          ndone;
    int          lat_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;

    rst           = 1'b1;
    md_if.start   = 1'b0;
    md_if.flush   = 1'b0;
    md_if.op      = MD_MULT;
    md_if.rs_data = '0;
    md_if.rt_data = '0;
    repeat (3) tick();
    chk("reset flags", 64'({md_if.busy, md_if.done, md_if.whi, md_if.wlo, md_if.div_by_zero}), 64'(0));
    chk("reset data", {md_if.wHiData, md_if.wLoData}, 64'(0));
    rst = 1'b0;
    tick();

    // Arithmetic vectors
    run_op("mult",     MD_MULT,  32'hFFFF_FFFE, 32'd3, MULC + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu",    MD_MULTU, 32'hFFFF_FFFE, 32'd3, MULC + 1, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_op("mult nn",  MD_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, MULC + 1, 32'h0, 32'h6, 1'b0);
    run_op("div neg",  MD_DIV,   32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div negb", MD_DIV,   32'd7, 32'hFFFF_FFFE, 34, 32'h1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",     MD_DIVU,  32'd100, 32'd7, 34, 32'h2, 32'hE, 1'b0);
    run_op("divu big", MD_DIVU,  32'hFFFF_FFFF, 32'h10, 34, 32'hF, 32'h0FFF_FFFF, 1'b0);
    run_op("div ovf",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu dz",  MD_DIVU,  32'h0000_1234, 32'd0, 2, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    run_op("div dz",   MD_DIV,   32'hFFFF_FFF9, 32'd0, 2, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // Flush mid-divide at k+10, new MULT at k+12
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    md_if.flush = 1'b1;
    tick();
    md_if.flush = 1'b0;
    chk("flush busy", 64'(md_if.busy), 64'(0));
    watch(1, ev);
    chk("flush no done", 64'(ev), 64'(0));
    run_op("post flush mult", MD_MULT, 32'd5, 32'd7, MULC + 1, 32'h0, 32'd35, 1'b0);
    watch(30, ev);
    chk("flushed div silent", 64'(ev), 64'(0));

    // start held through a DIV; operands change at k+5
    md_if.op      = MD_DIV;
    md_if.rs_data = 32'd100;
    md_if.rt_data = 32'd7;
    md_if.start   = 1'b1;
    tick();
    ndone = 0;
    lat_s = 0;
    hi_s  = '0;
    lo_s  = '0;
    for (int c = 1; c < 60; c++) begin
      if (c == 5) begin
        md_if.rs_data = 32'd9;
        md_if.rt_data = 32'd3;
      end
      if (md_if.done) begin
        ndone++;
        lat_s = c;
        hi_s  = md_if.wHiData;
        lo_s  = md_if.wLoData;
        md_if.start = 1'b0;
      end
      tick();
    end
    md_if.start = 1'b0;
    chk("held start one done", 64'(ndone), 64'(1));
    chk("held start latency", 64'(lat_s), 64'(34));
    chk("held start result", {hi_s, lo_s}, {32'h2, 32'hE});

    // Reset at k+20 discards the divide
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    chk("midop rst flags", 64'({md_if.busy, md_if.done, md_if.whi, md_if.wlo, md_if.div_by_zero}), 64'(0));
    chk("midop rst data", {md_if.wHiData, md_if.wLoData}, 64'(0));
    rst = 1'b0;
    watch(40, ev);
    chk("midop rst silent", 64'(ev), 64'(0));

    // flush together with start in IDLE drops the start
    md_if.op      = MD_MULT;
    md_if.rs_data = 32'd3;
    md_if.rt_data = 32'd3;
    md_if.start   = 1'b1;
    md_if.flush   = 1'b1;
    tick();
    md_if.start   = 1'b0;
    md_if.flush   = 1'b0;
    chk("flush+start busy", 64'(md_if.busy), 64'(0));
    watch(10, ev);
    chk("flush+start silent", 64'(ev), 64'(0));

    // flush in the DONE cycle suppresses done and writes
    issue(MD_MULT, 32'd2, 32'd3);
    wait_done(lat);
    chk("done-flush latency", 64'(lat), 64'(MULC + 1));
    md_if.flush = 1'b1;
    #1;
    chk("done-flush gated", 64'({md_if.done, md_if.whi, md_if.wlo}), 64'(0));
    tick();
    md_if.flush = 1'b0;
    chk("done-flush after", 64'({md_if.busy, md_if.done}), 64'(0));

    // start during DONE is ignored
    issue(MD_MULT, 32'd4, 32'd5);
    wait_done(lat);
    chk("done-start result", {md_if.wHiData, md_if.wLoData}, {32'h0, 32'd20});
    md_if.op      = MD_DIVU;
    md_if.rs_data = 32'd50;
    md_if.rt_data = 32'd5;
    md_if.start   = 1'b1;
    tick();
    md_if.start   = 1'b0;
    chk("done-start ignored", 64'({md_if.busy, md_if.done}), 64'(0));
    tick();
    chk("done-start still idle", 64'({md_if.busy, md_if.done}), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
